// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding
// and the default watchdog limit.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } arb_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 200000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: returns the first set request
// found searching upward from ptr, wrapping at N-1.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    logic [PW:0] cand;

    always_comb begin
        // NOTE: every output and temporary gets a default first, so no path
        // through the loop leaves a value held over (which would infer a latch).
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Walk from the farthest offset down so the nearest hit is written last.
        for (int off = N - 1; off >= 0; off--) begin
            cand = {1'b0, ptr} + (PW + 1)'(off);
            if (cand >= (PW + 1)'(N)) begin
                cand = cand - (PW + 1)'(N);
            end
            if (req[cand[PW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N requesters.
// Define UART_ARB_TIMEOUT_EN to add a watchdog that aborts a stuck byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          N       = 4,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   ack,
    output logic           busy,
    input  logic           uart_ready,
    input  logic           uart_finish,
    output logic           uart_send,
    output logic [7:0]     uart_data,
    output logic           timeout_err
);

    localparam int           PW      = $clog2(N);
    localparam logic [N-1:0] ONE_HOT = {{(N - 1){1'b0}}, 1'b1};

    if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("uart_tx_arbiter: N must be 2..8 and TIMEOUT at least 1");
    end

    arb_state_t    state, state_next;
    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic          wdog_hit;

    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (pick_valid && uart_ready) state_next = S_LAUNCH;
            S_LAUNCH: begin
                if (wdog_hit)         state_next = S_DONE;
                else if (!uart_ready) state_next = S_WAIT;
            end
            S_WAIT:   if (uart_finish || wdog_hit) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!Reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            ptr       <= '0;
            uart_data <= 8'h00;
        end else begin
            state <= state_next;
            if (state == S_IDLE && state_next == S_LAUNCH) begin
                idx       <= pick_idx;
                uart_data <= req_data[{pick_idx, 3'b000} +: 8];
            end
            // Granted source becomes lowest priority for the next round.
            if (state == S_DONE) begin
                ptr <= (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    assign uart_send = (state == S_LAUNCH);
    assign busy      = (state != S_IDLE);
    assign ack       = (state == S_DONE) ? (ONE_HOT << idx) : '0;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] wdog;
    logic        aborted;
    logic        abort_now;

    assign wdog_hit  = (state == S_LAUNCH || state == S_WAIT) && (wdog == 32'(TIMEOUT - 1));
    // A finish arriving on the expiry cycle wins: the byte completed normally.
    assign abort_now = wdog_hit && !(state == S_WAIT && uart_finish);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wdog    <= '0;
            aborted <= 1'b0;
        end else if (state == S_IDLE) begin
            wdog    <= '0;
            aborted <= 1'b0;
        end else if (state == S_LAUNCH || state == S_WAIT) begin
            wdog <= wdog + 32'd1;
            if (abort_now) aborted <= 1'b1;
        end
    end

    assign timeout_err = (state == S_DONE) && aborted;
`else
    assign wdog_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART transmitter model and a
// scoreboard of expected acks (requester, byte, timeout flag).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 50;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
        bit         to;
    } exp_t;

    logic           Clock;
    logic           Reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic           busy;
    logic           uart_ready;
    logic           uart_finish;
    logic           uart_send;
    logic [7:0]     uart_data;
    logic           timeout_err;

    uart_tx_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .busy        (busy),
        .uart_ready  (uart_ready),
        .uart_finish (uart_finish),
        .uart_send   (uart_send),
        .uart_data   (uart_data),
        .timeout_err (timeout_err)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Transmitter model: samples send on negedge, drops ready one cycle later,
    // pulses finish after fin_delay cycles unless hung.
    logic       m_ready, m_busy, m_pend, send_d;
    logic [7:0] cap_byte;
    int         m_cnt, abort_seen;
    logic       hold_nr, hang;
    int         fin_delay, abort_cnt;

    assign uart_ready = m_ready && !hold_nr;

    always @(negedge Clock or negedge Reset) begin
        if (!Reset) begin
            m_ready     = 1'b1;
            m_busy      = 1'b0;
            m_pend      = 1'b0;
            send_d      = 1'b0;
            uart_finish = 1'b0;
            cap_byte    = 8'h00;
            m_cnt       = 0;
            abort_seen  = abort_cnt;
        end else begin
            uart_finish = 1'b0;
            if (abort_cnt != abort_seen) begin
                abort_seen = abort_cnt;
                m_busy     = 1'b0;
                m_pend     = 1'b0;
                m_ready    = 1'b1;
            end else if (m_pend) begin
                m_ready = 1'b0;
                m_pend  = 1'b0;
            end else if (m_busy && !hang) begin
                if (m_cnt == 0) begin
                    uart_finish = 1'b1;
                    m_busy      = 1'b0;
                    m_ready     = 1'b1;
                end else begin
                    m_cnt--;
                end
            end
            if (uart_send && !send_d && m_ready && !m_busy) begin
                cap_byte = uart_data;
                m_busy   = 1'b1;
                m_pend   = 1'b1;
                m_cnt    = fin_delay;
            end
            send_d = uart_send;
        end
    end

    exp_t sb[$];
    int   n_vec, n_err, acks_done, cyc, send_cyc;
    logic send_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] i, input logic [7:0] d, input bit to);
        exp_t e;
        e.idx  = i;
        e.data = d;
        e.to   = to;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        cyc++;
        if (uart_send && !send_q) send_cyc = cyc;
        send_q = uart_send;
        if (!Reset) return;
        if (ack != '0 || uart_finish) begin
            if (sb.size() == 0) begin
                check("ack_spurious", 32'(ack), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack", 32'(ack), 32'(4'b0001 << e.idx));
                check("timeout_err", 32'(timeout_err), 32'(e.to));
                check("held_data", 32'(uart_data), 32'(e.data));
                check("tx_byte", 32'(cap_byte), 32'(e.data));
                if (e.to)
                    check("timeout_latency", 32'((cyc - send_cyc >= TMO) && (cyc - send_cyc <= TMO + 2)), 32'd1);
                else
                    check("ack_with_finish", 32'(uart_finish), 32'd1);
                acks_done++;
            end
        end else if (timeout_err) begin
            check("stray_timeout_err", 32'(timeout_err), 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        sample();
    endtask

    task automatic wait_acks(input int n, input int budget);
        int target = acks_done + n;
        int k = 0;
        while (acks_done < target && k < budget) begin
            tick();
            k++;
        end
        if (acks_done < target) check("ack_wait_expired", 32'(acks_done), 32'(target));
    endtask

    task automatic wait_in_wait(input int budget);
        int k = 0;
        while (!(busy && !uart_send && ack == '0 && !uart_ready) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) check("reach_wait_expired", 32'(k), 32'(budget - 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_send"}, 32'(uart_send), 32'd0);
        check({tag, "_data"}, 32'(uart_data), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    localparam logic [31:0] BYTES = {8'h13, 8'h12, 8'h11, 8'h10};

    initial begin
        n_vec = 0; n_err = 0; acks_done = 0; cyc = 0; send_cyc = 0; send_q = 1'b0;
        abort_cnt = 0; hold_nr = 1'b0; hang = 1'b0; fin_delay = 3;
        req = '0; req_data = BYTES;
        Reset = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        Reset = 1'b1;
        tick();

        // All requesters held: strict rotation from pointer 0.
        push_exp(2'd0, 8'h10, 0); push_exp(2'd1, 8'h11, 0); push_exp(2'd2, 8'h12, 0);
        push_exp(2'd3, 8'h13, 0); push_exp(2'd0, 8'h10, 0);
        req = 4'b1111;
        wait_acks(5, 120);
        req = '0;
        repeat (3) tick();

        // Single request: send and byte visible one cycle after req.
        req_data = {8'h13, 8'h12, 8'h11, 8'hA5};
        push_exp(2'd0, 8'hA5, 0);
        req = 4'b0001;
        tick();
        check("single_send", 32'(uart_send), 32'd1);
        check("single_data", 32'(uart_data), 32'hA5);
        wait_acks(1, 40);
        req = '0;
        req_data = BYTES;
        repeat (3) tick();

        // Move pointer to 2, then 1011 must be served 3,0,1.
        push_exp(2'd1, 8'h11, 0);
        req = 4'b0010;
        wait_acks(1, 40);
        req = '0;
        repeat (3) tick();
        push_exp(2'd3, 8'h13, 0); push_exp(2'd0, 8'h10, 0); push_exp(2'd1, 8'h11, 0);
        req = 4'b1011;
        wait_acks(3, 120);
        req = '0;
        repeat (3) tick();

        // Data and req changed after grant: original byte still goes out.
        fin_delay = 8;
        req_data = {8'h13, 8'h5C, 8'h11, 8'h10};
        push_exp(2'd2, 8'h5C, 0);
        req = 4'b0100;
        wait_in_wait(20);
        req_data = {8'h13, 8'hFF, 8'h11, 8'h10};
        req = '0;
        wait_acks(1, 40);
        fin_delay = 3;
        req_data = BYTES;
        repeat (3) tick();

        // Transmitter not ready: no grant until released.
        hold_nr = 1'b1;
        push_exp(2'd2, 8'h12, 0);
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_send", 32'(uart_send), 32'd0);
            check("stall_busy", 32'(busy), 32'd0);
        end
        hold_nr = 1'b0;
        tick();
        check("release_send", 32'(uart_send), 32'd1);
        wait_acks(1, 40);
        req = '0;
        repeat (3) tick();

        // Reset mid-byte: outputs clear at once, pointer restarts at 0.
        push_exp(2'd3, 8'h13, 0);
        req = 4'b1010;
        wait_in_wait(20);
        #2 Reset = 1'b0;
        #1 check_reset_outputs("midreset");
        sb.delete();
        repeat (2) tick();
        Reset = 1'b1;
        push_exp(2'd1, 8'h11, 0);
        wait_acks(1, 40);
        req = '0;
        repeat (3) tick();

`ifdef UART_ARB_TIMEOUT_EN
        // Hung transmitter: watchdog aborts, next requester is then served.
        hang = 1'b1;
        push_exp(2'd0, 8'h10, 1);
        push_exp(2'd1, 8'h11, 0);
        req = 4'b0011;
        wait_acks(1, TMO + 30);
        hang = 1'b0;
        abort_cnt++;
        req = 4'b0010;
        wait_acks(1, 40);
        req = '0;
        repeat (3) tick();
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART byte transmitter among N independent requesters (console, debug monitor, DMA, etc.). Round-robin selection across requesters, drives the transmitter's edge-triggered `send`/`data` inputs, waits for its `finish` pulse, and returns a one-cycle per-requester `ack`. Sits between the requester blocks and the UART transmitter; `Baud` routes directly to the transmitter and does not pass through this block.

## Interface
- `N`, 4: number of requesters, legal range 2..8.
- `TIMEOUT`, 200000: watchdog limit in Clock cycles. Used only when `UART_ARB_TIMEOUT_EN` is defined.
- `Clock`  in  1  system clock; all state updates on posedge.
- `Reset`  in  1  reset, asynchronous, active-low.
- `req`  in  N  request per requester. Level; held until the matching `ack`.
- `req_data`  in  8*N  byte for requester i at bits [8i+7:8i]. Sampled only at grant.
- `ack`  out  N  one-hot, one-cycle pulse: granted byte finished or aborted.
- `busy`  out  1  high in every state except S_IDLE.
- `uart_ready`  in  1  transmitter idle and out of reset.
- `uart_finish`  in  1  transmitter one-cycle done pulse.
- `uart_send`  out  1  level to the transmitter; it detects the rising edge.
- `uart_data`  out  8  byte to the transmitter.
- `timeout_err`  out  1  one-cycle pulse coincident with `ack` when the byte was aborted by the watchdog.

## Operation
- Reset values: state S_IDLE, `ack`=0, `busy`=0, `uart_send`=0, `uart_data`=8'h00, `timeout_err`=0, rr pointer=0, watchdog=0.
- States and transitions:
  - S_IDLE: if `|req` and `uart_ready`, grant the first set `req` bit searching upward from the pointer with wrap. Latch the index and `req_data` slice into `uart_data`, then go to S_LAUNCH. Otherwise stay.
  - S_LAUNCH: `uart_send`=1. When `uart_ready`=0, the transmitter has accepted the byte; go to S_WAIT.
  - S_WAIT: `uart_send`=0. When `uart_finish`=1, go to S_DONE.
  - S_DONE: `ack[idx]`=1 for exactly this cycle. Pointer <= (idx+1) mod N. Go to S_IDLE.
- `uart_data` holds the latched byte from S_LAUNCH through S_DONE. Later changes to `req_data` have no effect.
- A requester that drops `req` after grant still gets its byte sent and its `ack` pulsed.
- A requester that holds `req` past `ack` is re-arbitrated as lowest priority, so back-to-back bytes from one source interleave fairly.
- A `uart_finish` seen outside S_WAIT is ignored.
- If `uart_ready`=0 in S_IDLE, no grant is made.
- Pointer arithmetic uses $clog2(N) bits. For N not a power of two, the pointer wraps explicitly from N-1 to 0.

## Timing
- `req` high at edge t in S_IDLE: `uart_send`=1 and `uart_data` valid after edge t+1.
- The transmitter samples `send` on negedge and drops `ready` one posedge later. S_LAUNCH therefore lasts 2 cycles in normal operation.
- `ack` asserts on the cycle after the `uart_finish` cycle.
- Minimum gap between grants is 2 cycles (S_DONE, S_IDLE). `uart_send` is low for at least 3 cycles between launches, which guarantees a clean rising edge.
- Reset asserted mid-operation immediately returns all outputs to their reset values. The transmitter shares `Reset` and aborts in step.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 32-bit watchdog clears on entry to S_LAUNCH and increments in S_LAUNCH and S_WAIT.
  - On reaching `TIMEOUT`, go to S_DONE and pulse `timeout_err` together with `ack`.
  - `uart_send` drops at that point. The pointer advances as normal.
- Not defined: no counter; S_LAUNCH and S_WAIT wait indefinitely; `timeout_err` is tied to 0. The port is always present.

## Structure
- Shared package `uart_pkg`: arbiter state encodings (S_IDLE=2'd0, S_LAUNCH=2'd1, S_WAIT=2'd2, S_DONE=2'd3) and the default `TIMEOUT`.
- Sub-module `rr_pick`: purely combinational round-robin priority encoder. Inputs are `req` and the pointer; outputs are `valid` and the index. The arbiter FSM, data latch and watchdog stay in `uart_tx_arbiter`.

## Test plan
- Single request: `req`=4'b0001, data 8'hA5 → `uart_send` rises 1 cycle later, `uart_data`=8'hA5, `ack`=4'b0001 one cycle after the model's `finish`.
- All requesters held with bytes 8'h10..8'h13 → order 0,1,2,3,0 and each `ack` is one-hot. Then with pointer at 2 and `req`=4'b1011 → order 3,0,1.
- `req_data` changed and `req` dropped during S_WAIT → the original byte is still transmitted and `ack` still pulses.
- `uart_ready` held 0 with `req`=4'b0100 → no grant and `uart_send` stays 0; release → grant within 1 cycle.
- `Reset` pulled low during S_WAIT → all outputs return to reset values at once; on release, the held `req` is re-granted from pointer 0.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT`=50, the model never finishes → `ack` and `timeout_err` pulse together at cycle ~51 after grant, and the next requester is served.
